// File: rtl/sdr_chan_pkg.sv
// Shared definitions for the SDR channel models: the rotation encodings, the LFSR
// tap mask and a generic signed clamp.
package sdr_chan_pkg;

    typedef enum logic [1:0] {
        ROT_0   = 2'd0,
        ROT_90  = 2'd1,
        ROT_180 = 2'd2,
        ROT_270 = 2'd3
    } rot_e;

    // Galois right-shift mask for the x^16 + x^14 + x^13 + x^11 + 1 polynomial.
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    function automatic logic signed [31:0] sat_clip(input logic signed [31:0] x,
                                                    input int unsigned w);
        logic signed [31:0] hi;
        logic signed [31:0] lo;
        hi = (32'sd1 <<< (w - 1)) - 32'sd1;
        lo = -(32'sd1 <<< (w - 1));
        if (x > hi) return hi;
        if (x < lo) return lo;
        return x;
    endfunction

endpackage

// File: rtl/lfsr16.sv
// Free-running 16-bit Galois LFSR; loads SEED in reset and advances on every clock after.
module lfsr16
    import sdr_chan_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [15:0] state
);

    logic [15:0] state_d;
    logic [15:0] state_q;

    always_comb begin
        state_d = {1'b0, state_q[15:1]} ^ (state_q[0] ? LFSR_TAPS : 16'h0000);
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= SEED;
        else        state_q <= state_d;
    end

    assign state = state_q;

endmodule

// File: rtl/loopback_channel.sv
// Baseband loopback channel: rotate, scale, add LFSR noise with saturation, then a
// selectable delay tap. Latency is 4 + DELAY_CFG clocks.
module loopback_channel
    import sdr_chan_pkg::*;
#(
    parameter int          DATA_W      = 12,
    parameter int          MAX_DELAY   = 16,
    parameter logic [15:0] LFSR_SEED_I = 16'hACE1,
    parameter logic [15:0] LFSR_SEED_Q = 16'h1D2B
) (
    input  logic                         clk_32M768,
    input  logic                         rst_n_32M768,
    input  logic signed [DATA_W-1:0]     DAC_I,
    input  logic signed [DATA_W-1:0]     DAC_Q,
    input  logic                         DAC_valid,
    input  logic [3:0]                   GAIN_NUM,
    input  logic                         NOISE_EN,
    input  logic [3:0]                   NOISE_SHIFT,
    input  logic [1:0]                   ROT_CFG,
    input  logic [$clog2(MAX_DELAY)-1:0] DELAY_CFG,
    input  logic                         SAT_CLR,
    output logic signed [DATA_W-1:0]     ADC_I,
    output logic signed [DATA_W-1:0]     ADC_Q,
    output logic                         ADC_valid,
    output logic [15:0]                  sat_count
);

    localparam int AW = DATA_W + 4;
    localparam int SW = AW + 1;

    logic [15:0] lfsr_i, lfsr_q;

    lfsr16 #(.SEED(LFSR_SEED_I)) u_lfsr_i (.clk(clk_32M768), .rst_n(rst_n_32M768), .state(lfsr_i));
    lfsr16 #(.SEED(LFSR_SEED_Q)) u_lfsr_q (.clk(clk_32M768), .rst_n(rst_n_32M768), .state(lfsr_q));

    logic signed [DATA_W-1:0] s1_i_d, s1_i_q, s1_q_d, s1_q_q;
    logic                     s1_v_d, s1_v_q;
    logic signed [AW-1:0]     s2_i_d, s2_i_q, s2_q_d, s2_q_q;
    logic                     s2_v_d, s2_v_q;
    logic signed [DATA_W-1:0] dl_i_d [MAX_DELAY];
    logic signed [DATA_W-1:0] dl_i_q [MAX_DELAY];
    logic signed [DATA_W-1:0] dl_q_d [MAX_DELAY];
    logic signed [DATA_W-1:0] dl_q_q [MAX_DELAY];
    logic [MAX_DELAY-1:0]     dl_v_d, dl_v_q;
    logic signed [DATA_W-1:0] adc_i_d, adc_i_q, adc_q_d, adc_q_q;
    logic                     adc_v_d, adc_v_q;
    logic [15:0]              sat_count_d, sat_count_q;

    logic signed [DATA_W-1:0] neg_i, neg_q;
    logic signed [AW-1:0]     prod_i, prod_q;
    logic signed [DATA_W-2:0] raw_i, raw_q, noise_i, noise_q;
    logic signed [SW-1:0]     sum_i, sum_q;
    logic signed [DATA_W-1:0] clip_i, clip_q;
    logic                     sat_hit;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        s1_i_d = '0;
        s1_q_d = '0;
        s1_v_d = DAC_valid;
        neg_i  = DATA_W'(sat_clip(-32'(DAC_I), DATA_W));
        neg_q  = DATA_W'(sat_clip(-32'(DAC_Q), DATA_W));
        if (DAC_valid) begin
            case (rot_e'(ROT_CFG))
                ROT_0:   begin s1_i_d = DAC_I; s1_q_d = DAC_Q; end
                ROT_90:  begin s1_i_d = neg_q; s1_q_d = DAC_I; end
                ROT_180: begin s1_i_d = neg_i; s1_q_d = neg_q; end
                default: begin s1_i_d = DAC_Q; s1_q_d = neg_i; end
            endcase
        end

        // NOTE: signed shifts stay in their own statements; a ?: with an unsigned '0 arm would make >>> logical.
        s2_i_d = '0;
        s2_q_d = '0;
        s2_v_d = s1_v_q;
        prod_i = AW'(s1_i_q) * AW'($signed({1'b0, GAIN_NUM}));
        prod_q = AW'(s1_q_q) * AW'($signed({1'b0, GAIN_NUM}));
        if (s1_v_q) begin
            s2_i_d = prod_i >>> 2;
            s2_q_d = prod_q >>> 2;
        end

        raw_i   = $signed(lfsr_i[DATA_W-2:0]);
        raw_q   = $signed(lfsr_q[DATA_W-2:0]);
        noise_i = '0;
        noise_q = '0;
        if (NOISE_EN) begin
            noise_i = raw_i >>> NOISE_SHIFT;
            noise_q = raw_q >>> NOISE_SHIFT;
        end
        sum_i   = SW'(s2_i_q) + SW'(noise_i);
        sum_q   = SW'(s2_q_q) + SW'(noise_q);
        clip_i  = DATA_W'(sat_clip(32'(sum_i), DATA_W));
        clip_q  = DATA_W'(sat_clip(32'(sum_q), DATA_W));
        sat_hit = s2_v_q && ((sum_i != SW'(clip_i)) || (sum_q != SW'(clip_q)));

        // Tap 0 of the delay line is the stage-3 register itself.
        dl_i_d[0] = '0;
        dl_q_d[0] = '0;
        if (s2_v_q) begin
            dl_i_d[0] = clip_i;
            dl_q_d[0] = clip_q;
        end
        dl_v_d[0] = s2_v_q;
        for (int k = 1; k < MAX_DELAY; k++) begin
            dl_i_d[k] = dl_i_q[k-1];
            dl_q_d[k] = dl_q_q[k-1];
            dl_v_d[k] = dl_v_q[k-1];
        end

        adc_i_d = dl_i_q[DELAY_CFG];
        adc_q_d = dl_q_q[DELAY_CFG];
        adc_v_d = dl_v_q[DELAY_CFG];

        sat_count_d = sat_count_q;
        if (SAT_CLR)                                 sat_count_d = '0;
        else if (sat_hit && sat_count_q != 16'hFFFF) sat_count_d = sat_count_q + 16'd1;
    end

    always_ff @(posedge clk_32M768) begin
        if (!rst_n_32M768) begin
            s1_i_q <= '0; s1_q_q <= '0; s1_v_q <= 1'b0;
            s2_i_q <= '0; s2_q_q <= '0; s2_v_q <= 1'b0;
            // NOTE: the delay line is cleared too, so no stale valid sample survives a reset.
            for (int k = 0; k < MAX_DELAY; k++) begin
                dl_i_q[k] <= '0;
                dl_q_q[k] <= '0;
            end
            dl_v_q      <= '0;
            adc_i_q     <= '0;
            adc_q_q     <= '0;
            adc_v_q     <= 1'b0;
            sat_count_q <= '0;
        end else begin
            s1_i_q <= s1_i_d; s1_q_q <= s1_q_d; s1_v_q <= s1_v_d;
            s2_i_q <= s2_i_d; s2_q_q <= s2_q_d; s2_v_q <= s2_v_d;
            dl_i_q      <= dl_i_d;
            dl_q_q      <= dl_q_d;
            dl_v_q      <= dl_v_d;
            adc_i_q     <= adc_i_d;
            adc_q_q     <= adc_q_d;
            adc_v_q     <= adc_v_d;
            sat_count_q <= sat_count_d;
        end
    end

    assign ADC_I     = adc_i_q;
    assign ADC_Q     = adc_q_q;
    assign ADC_valid = adc_v_q;
    assign sat_count = sat_count_q;

endmodule

// File: tb/tb_loopback_channel.sv
// Scoreboard bench for loopback_channel: expected samples are queued with their due
// cycle when driven, and matched against every valid output captured by the monitor.
module tb_loopback_channel;

    localparam int DW = 12;

    typedef struct {
        int due;
        int i;
        int q;
    } smp_t;

    logic                 clk;
    logic                 rst_n;
    logic signed [DW-1:0] DAC_I, DAC_Q, ADC_I, ADC_Q;
    logic                 DAC_valid, NOISE_EN, SAT_CLR, ADC_valid;
    logic [3:0]           GAIN_NUM, NOISE_SHIFT, DELAY_CFG;
    logic [1:0]           ROT_CFG;
    logic [15:0]          sat_count;

    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    smp_t exp_q[$];
    smp_t obs_q[$];

    loopback_channel dut (
        .clk_32M768  (clk),
        .rst_n_32M768(rst_n),
        .DAC_I       (DAC_I),
        .DAC_Q       (DAC_Q),
        .DAC_valid   (DAC_valid),
        .GAIN_NUM    (GAIN_NUM),
        .NOISE_EN    (NOISE_EN),
        .NOISE_SHIFT (NOISE_SHIFT),
        .ROT_CFG     (ROT_CFG),
        .DELAY_CFG   (DELAY_CFG),
        .SAT_CLR     (SAT_CLR),
        .ADC_I       (ADC_I),
        .ADC_Q       (ADC_Q),
        .ADC_valid   (ADC_valid),
        .sat_count   (sat_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (ADC_valid === 1'b1) obs_q.push_back('{cyc, int'(ADC_I), int'(ADC_Q)});
    end

    function automatic int sat_n(input int x);
        if (x > 2047)  return 2047;
        if (x < -2048) return -2048;
        return x;
    endfunction

    function automatic int neg_n(input int x);
        return (x == -2048) ? 2047 : -x;
    endfunction

    function automatic void model(input int xi, input int xq, input int rot, input int gain,
                                  output int oi, output int oq);
        int ri, rq;
        case (rot)
            0:       begin ri = xi;        rq = xq;        end
            1:       begin ri = neg_n(xq); rq = xi;        end
            2:       begin ri = neg_n(xi); rq = neg_n(xq); end
            default: begin ri = xq;        rq = neg_n(xi); end
        endcase
        oi = sat_n((ri * gain) >>> 2);
        oq = sat_n((rq * gain) >>> 2);
    endfunction

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {1'b0, s[15:1]} ^ (s[0] ? 16'hB400 : 16'h0000);
    endfunction

    function automatic int noise_of(input logic [15:0] s, input int sh);
        int v;
        v = int'(s[10:0]);
        if (v >= 1024) v -= 2048;
        return v >>> sh;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    task automatic send(input int xi, input int xq);
        int ei, eq;
        model(xi, xq, int'(ROT_CFG), int'(GAIN_NUM), ei, eq);
        DAC_I     = DW'(xi);
        DAC_Q     = DW'(xq);
        DAC_valid = 1'b1;
        exp_q.push_back('{cyc + 4 + int'(DELAY_CFG), ei, eq});
        step();
        DAC_valid = 1'b0;
        DAC_I     = '0;
        DAC_Q     = '0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; DAC_I = 12'sd123; DAC_Q = -12'sd77; DAC_valid = 1'b1;
        GAIN_NUM = 4'd4; NOISE_EN = 1'b0; NOISE_SHIFT = 4'd0; ROT_CFG = 2'd0;
        DELAY_CFG = 4'd0; SAT_CLR = 1'b0;
        idle(6);
        @(negedge clk);
        total++; if (ADC_valid !== 1'b0)  begin bad++; $display("FAIL rst_valid: got %b want 0", ADC_valid); end
        total++; if (ADC_I !== 12'sd0)    begin bad++; $display("FAIL rst_adc_i: got %0d want 0", ADC_I); end
        total++; if (ADC_Q !== 12'sd0)    begin bad++; $display("FAIL rst_adc_q: got %0d want 0", ADC_Q); end
        total++; if (sat_count !== 16'd0) begin bad++; $display("FAIL rst_sat: got %0d want 0", sat_count); end
        step();
        DAC_valid = 1'b0; DAC_I = '0; DAC_Q = '0; rst_n = 1'b1;
        idle(2);
    endtask

    task automatic test_passthrough();
        smp_t e, o;
        exp_q.delete(); obs_q.delete();
        GAIN_NUM = 4'd4; ROT_CFG = 2'd0; DELAY_CFG = 4'd0; NOISE_EN = 1'b0;
        send(100, -50);
        idle(24);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); total++;
            if (obs_q.size() == 0) begin bad++; $display("FAIL t1_out: missing, want cyc=%0d (%0d,%0d)", e.due, e.i, e.q); end
            else begin
                o = obs_q.pop_front();
                if (o.due !== e.due || o.i !== e.i || o.q !== e.q) begin
                    bad++; $display("FAIL t1_out: got cyc=%0d (%0d,%0d) want cyc=%0d (%0d,%0d)", o.due, o.i, o.q, e.due, e.i, e.q);
                end
            end
        end
        total++; if (obs_q.size() != 0) begin bad++; $display("FAIL t1_extra: got %0d extra valid outputs want 0", obs_q.size()); end
    endtask

    task automatic test_rot_gain_delay();
        smp_t e, o;
        exp_q.delete(); obs_q.delete();
        GAIN_NUM = 4'd3; ROT_CFG = 2'd1; DELAY_CFG = 4'd5;
        send(400, -800);
        idle(30);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); total++;
            if (obs_q.size() == 0) begin bad++; $display("FAIL t2_out: missing, want cyc=%0d (%0d,%0d)", e.due, e.i, e.q); end
            else begin
                o = obs_q.pop_front();
                if (o.due !== e.due || o.i !== e.i || o.q !== e.q) begin
                    bad++; $display("FAIL t2_out: got cyc=%0d (%0d,%0d) want cyc=%0d (%0d,%0d)", o.due, o.i, o.q, e.due, e.i, e.q);
                end
            end
        end
        total++; if (obs_q.size() != 0) begin bad++; $display("FAIL t2_extra: got %0d extra valid outputs want 0", obs_q.size()); end
    endtask

    task automatic test_saturation();
        smp_t e, o;
        exp_q.delete(); obs_q.delete();
        GAIN_NUM = 4'd15; ROT_CFG = 2'd0; DELAY_CFG = 4'd0;
        SAT_CLR = 1'b1; step(); SAT_CLR = 1'b0;
        for (int k = 0; k < 10; k++) send(2047, -2048);
        idle(24);
        total++; if (sat_count !== 16'd10) begin bad++; $display("FAIL t3_sat_count: got %0d want 10", sat_count); end
        // Clear is held while one more saturating sample passes through stage 3.
        SAT_CLR = 1'b1;
        send(2047, -2048);
        idle(2);
        SAT_CLR = 1'b0;
        idle(24);
        total++; if (sat_count !== 16'd0) begin bad++; $display("FAIL t3_sat_clr: got %0d want 0", sat_count); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); total++;
            if (obs_q.size() == 0) begin bad++; $display("FAIL t3_out: missing, want cyc=%0d (%0d,%0d)", e.due, e.i, e.q); end
            else begin
                o = obs_q.pop_front();
                if (o.due !== e.due || o.i !== e.i || o.q !== e.q) begin
                    bad++; $display("FAIL t3_out: got cyc=%0d (%0d,%0d) want cyc=%0d (%0d,%0d)", o.due, o.i, o.q, e.due, e.i, e.q);
                end
            end
        end
        total++; if (obs_q.size() != 0) begin bad++; $display("FAIL t3_extra: got %0d extra valid outputs want 0", obs_q.size()); end
    endtask

    task automatic test_rot180();
        smp_t e, o;
        exp_q.delete(); obs_q.delete();
        GAIN_NUM = 4'd15; ROT_CFG = 2'd2; DELAY_CFG = 4'd0;
        send(-2048, -2048);
        idle(24);
        total++; if (sat_count !== 16'd1) begin bad++; $display("FAIL t6_sat_count: got %0d want 1", sat_count); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); total++;
            if (obs_q.size() == 0) begin bad++; $display("FAIL t6_out: missing, want cyc=%0d (%0d,%0d)", e.due, e.i, e.q); end
            else begin
                o = obs_q.pop_front();
                if (o.due !== e.due || o.i !== e.i || o.q !== e.q) begin
                    bad++; $display("FAIL t6_out: got cyc=%0d (%0d,%0d) want cyc=%0d (%0d,%0d)", o.due, o.i, o.q, e.due, e.i, e.q);
                end
            end
        end
        total++; if (obs_q.size() != 0) begin bad++; $display("FAIL t6_extra: got %0d extra valid outputs want 0", obs_q.size()); end
    endtask

    task automatic test_back_to_back();
        smp_t e, o;
        exp_q.delete(); obs_q.delete();
        GAIN_NUM = 4'd2; DELAY_CFG = 4'd3;
        for (int k = 0; k < 12; k++) begin
            ROT_CFG = 2'($urandom_range(0, 3));
            send(int'($urandom_range(0, 4095)) - 2048, int'($urandom_range(0, 4095)) - 2048);
            if (k % 3 == 2) step();
        end
        idle(30);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); total++;
            if (obs_q.size() == 0) begin bad++; $display("FAIL b2b_out: missing, want cyc=%0d (%0d,%0d)", e.due, e.i, e.q); end
            else begin
                o = obs_q.pop_front();
                if (o.due !== e.due || o.i !== e.i || o.q !== e.q) begin
                    bad++; $display("FAIL b2b_out: got cyc=%0d (%0d,%0d) want cyc=%0d (%0d,%0d)", o.due, o.i, o.q, e.due, e.i, e.q);
                end
            end
        end
        total++; if (obs_q.size() != 0) begin bad++; $display("FAIL b2b_extra: got %0d extra valid outputs want 0", obs_q.size()); end
    endtask

    task automatic test_noise();
        int out_rng, sum_i, sum_q, diff;
        exp_q.delete(); obs_q.delete();
        GAIN_NUM = 4'd4; ROT_CFG = 2'd0; DELAY_CFG = 4'd0;
        NOISE_EN = 1'b1; NOISE_SHIFT = 4'd2;
        DAC_I = '0; DAC_Q = '0; DAC_valid = 1'b1;
        idle(4096);
        DAC_valid = 1'b0;
        idle(8);
        NOISE_EN = 1'b0;
        out_rng = 0; sum_i = 0; sum_q = 0; diff = 0;
        foreach (obs_q[k]) begin
            if (obs_q[k].i < -256 || obs_q[k].i > 255) out_rng++;
            if (obs_q[k].q < -256 || obs_q[k].q > 255) out_rng++;
            sum_i += obs_q[k].i;
            sum_q += obs_q[k].q;
            if (obs_q[k].i != obs_q[k].q) diff++;
        end
        total++; if (obs_q.size() != 4096) begin bad++; $display("FAIL t4_count: got %0d samples want 4096", obs_q.size()); end
        total++; if (out_rng != 0) begin bad++; $display("FAIL t4_range: got %0d values outside [-256,255] want 0", out_rng); end
        total++; if (sum_i > 8 * 4096 || sum_i < -8 * 4096) begin bad++; $display("FAIL t4_mean_i: got sum %0d want |sum|<=%0d", sum_i, 8 * 4096); end
        total++; if (sum_q > 8 * 4096 || sum_q < -8 * 4096) begin bad++; $display("FAIL t4_mean_q: got sum %0d want |sum|<=%0d", sum_q, 8 * 4096); end
        total++; if (diff == 0) begin bad++; $display("FAIL t4_iq_differ: got %0d differing samples want >0", diff); end
        obs_q.delete();
    endtask

    task automatic test_reset_midstream();
        logic [15:0] si, sq;
        GAIN_NUM = 4'd4; ROT_CFG = 2'd0; DELAY_CFG = 4'd0;
        NOISE_EN = 1'b1; NOISE_SHIFT = 4'd0;
        DAC_I = '0; DAC_Q = '0; DAC_valid = 1'b1;
        idle(10);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            total++;
            if (ADC_valid !== 1'b0 || ADC_I !== 12'sd0 || ADC_Q !== 12'sd0) begin
                bad++; $display("FAIL t5_flush[%0d]: got v=%b (%0d,%0d) want v=0 (0,0)", k, ADC_valid, ADC_I, ADC_Q);
            end
        end
        si = lfsr_next(lfsr_next(16'hACE1));
        sq = lfsr_next(lfsr_next(16'h1D2B));
        for (int n = 0; n < 16; n++) begin
            @(negedge clk);
            total++;
            if (ADC_valid !== 1'b1 || int'(ADC_I) != noise_of(si, 0) || int'(ADC_Q) != noise_of(sq, 0)) begin
                bad++; $display("FAIL t5_seed[%0d]: got v=%b (%0d,%0d) want v=1 (%0d,%0d)",
                                n, ADC_valid, ADC_I, ADC_Q, noise_of(si, 0), noise_of(sq, 0));
            end
            si = lfsr_next(si);
            sq = lfsr_next(sq);
        end
        DAC_valid = 1'b0;
        NOISE_EN  = 1'b0;
        idle(24);
        obs_q.delete();
    endtask

    initial begin
        test_reset();
        test_passthrough();
        test_rot_gain_delay();
        test_saturation();
        test_rot180();
        test_back_to_back();
        test_noise();
        test_reset_midstream();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
